// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the core stages.
// The master side is pipe_ctrl; the slave side is the core (EX, ID, interrupt source).
interface pipe_ctrl_if #(
   parameter int unsigned AW = 32
);
   logic          jump_req_i;
   logic [AW-1:0] jump_addr_i;
   logic          ex_busy_i;
   logic          load_use_i;
   logic          irq_req_i;
   logic [AW-1:0] irq_vec_i;
   logic          irq_ack_o;
   logic          redirect_o;
   logic [AW-1:0] redirect_addr_o;
   logic          stall_pc_o;
   logic          stall_if_id_o;
   logic          stall_id_ex_o;
   logic          flush_if_id_o;
   logic          flush_id_ex_o;
   logic [31:0]   stall_cnt_o;

   modport master (
      input  jump_req_i, jump_addr_i, ex_busy_i, load_use_i, irq_req_i, irq_vec_i,
      output irq_ack_o, redirect_o, redirect_addr_o, stall_pc_o, stall_if_id_o,
             stall_id_ex_o, flush_if_id_o, flush_id_ex_o, stall_cnt_o
   );

   modport slave (
      output jump_req_i, jump_addr_i, ex_busy_i, load_use_i, irq_req_i, irq_vec_i,
      input  irq_ack_o, redirect_o, redirect_addr_o, stall_pc_o, stall_if_id_o,
             stall_id_ex_o, flush_if_id_o, flush_id_ex_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 3-stage core: arbitrates jumps, interrupts, EX busy and
// load-use hazards into per-stage stall/flush controls and a same-cycle PC redirect.
module pipe_ctrl #(
   parameter int unsigned AW             = 32,
   parameter int unsigned FLUSH_CYCLES   = 1,
   parameter logic [31:0] STALL_CNT_INIT = 32'h0
) (
   input logic         clk,
   input logic         rstn,
   pipe_ctrl_if.master bus
);

   localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES);

   typedef enum logic [0:0] {StRun, StFlush} state_t;

   state_t      state;
   logic [2:0]  fcnt;
   logic [31:0] stall_cnt;
   logic        take_jump;
   logic        take_irq;

   // Priority: reset > EX busy > jump > flush in progress > load-use > interrupt.
   always_comb begin
      take_jump = bus.jump_req_i & ~bus.ex_busy_i;
      take_irq  = (state == StRun) & ~bus.ex_busy_i & ~bus.jump_req_i & ~bus.load_use_i &
                  bus.irq_req_i;
   end

   always_comb begin
      bus.irq_ack_o       = 1'b0;
      bus.redirect_o      = 1'b0;
      bus.redirect_addr_o = '0;
      bus.stall_pc_o      = 1'b0;
      bus.stall_if_id_o   = 1'b0;
      bus.stall_id_ex_o   = 1'b0;
      bus.flush_if_id_o   = 1'b0;
      bus.flush_id_ex_o   = 1'b0;
      bus.stall_cnt_o     = stall_cnt;
      if (!rstn) begin
         bus.flush_if_id_o = 1'b1;
         bus.flush_id_ex_o = 1'b1;
      end else if (bus.ex_busy_i) begin
         bus.stall_pc_o    = 1'b1;
         bus.stall_if_id_o = 1'b1;
         bus.stall_id_ex_o = 1'b1;
         // Wrong-path fetch still in if_id: flush overrides the stall there.
         bus.flush_if_id_o = (state == StFlush);
      end else if (take_jump) begin
         bus.redirect_o      = 1'b1;
         bus.redirect_addr_o = bus.jump_addr_i;
         bus.flush_if_id_o   = 1'b1;
         bus.flush_id_ex_o   = 1'b1;
      end else if (state == StFlush) begin
         bus.flush_if_id_o = 1'b1;
      end else if (bus.load_use_i) begin
         bus.stall_pc_o    = 1'b1;
         bus.stall_if_id_o = 1'b1;
         bus.flush_id_ex_o = 1'b1;
      end else if (take_irq) begin
         bus.irq_ack_o       = 1'b1;
         bus.redirect_o      = 1'b1;
         bus.redirect_addr_o = bus.irq_vec_i;
         bus.flush_if_id_o   = 1'b1;
         bus.flush_id_ex_o   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= StRun;
         fcnt      <= 3'd0;
         stall_cnt <= STALL_CNT_INIT;
      end else begin
         if (bus.stall_pc_o) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (take_jump || take_irq) begin
            if (FLUSH_CYCLES > 0) begin
               state <= StFlush;
               fcnt  <= FCNT_LOAD;
            end else begin
               state <= StRun;
               fcnt  <= 3'd0;
            end
         end else if (state == StFlush && !bus.ex_busy_i) begin
            fcnt <= fcnt - 3'd1;
            if (fcnt == 3'd1) begin
               state <= StRun;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a behavioural model for two configurations.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.AW(32)) bus0 ();
   pipe_ctrl_if #(.AW(32)) bus1 ();

   assign bus1.jump_req_i  = bus0.jump_req_i;
   assign bus1.jump_addr_i = bus0.jump_addr_i;
   assign bus1.ex_busy_i   = bus0.ex_busy_i;
   assign bus1.load_use_i  = bus0.load_use_i;
   assign bus1.irq_req_i   = bus0.irq_req_i;
   assign bus1.irq_vec_i   = bus0.irq_vec_i;

   pipe_ctrl #(.AW(32), .FLUSH_CYCLES(1)) dut0 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus0.master)
   );

   pipe_ctrl #(.AW(32), .FLUSH_CYCLES(3), .STALL_CNT_INIT(32'hFFFF_FFFE)) dut1 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus1.master)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        irq_ack;
      logic        redirect;
      logic [31:0] addr;
      logic        stall_pc;
      logic        stall_if_id;
      logic        stall_id_ex;
      logic        flush_if_id;
      logic        flush_id_ex;
   } outs_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // left = wrong-path cycles still to flush after the current one.
   function automatic outs_t predict(input logic r, b, j, l, i, input logic [31:0] ja, iv,
                                     input int left, input int fc, output int left_n);
      outs_t o = '0;
      left_n = left;
      if (!r) begin
         o.flush_if_id = 1'b1;
         o.flush_id_ex = 1'b1;
         left_n = 0;
      end else if (b) begin
         o.stall_pc    = 1'b1;
         o.stall_if_id = 1'b1;
         o.stall_id_ex = 1'b1;
         o.flush_if_id = (left > 0);
      end else if (j) begin
         o.redirect    = 1'b1;
         o.addr        = ja;
         o.flush_if_id = 1'b1;
         o.flush_id_ex = 1'b1;
         left_n = fc;
      end else if (left > 0) begin
         o.flush_if_id = 1'b1;
         left_n = left - 1;
      end else if (l) begin
         o.stall_pc    = 1'b1;
         o.stall_if_id = 1'b1;
         o.flush_id_ex = 1'b1;
      end else if (i) begin
         o.irq_ack     = 1'b1;
         o.redirect    = 1'b1;
         o.addr        = iv;
         o.flush_if_id = 1'b1;
         o.flush_id_ex = 1'b1;
         left_n = fc;
      end
      return o;
   endfunction

   task automatic check_inst(input string tag, input outs_t e, input outs_t a,
                             input logic [31:0] ce, input logic [31:0] ca);
      chk({tag, ".irq_ack"},     32'(a.irq_ack),     32'(e.irq_ack));
      chk({tag, ".redirect"},    32'(a.redirect),    32'(e.redirect));
      chk({tag, ".redir_addr"},  a.addr,             e.addr);
      chk({tag, ".stall_pc"},    32'(a.stall_pc),    32'(e.stall_pc));
      chk({tag, ".stall_if_id"}, 32'(a.stall_if_id), 32'(e.stall_if_id));
      chk({tag, ".stall_id_ex"}, 32'(a.stall_id_ex), 32'(e.stall_id_ex));
      chk({tag, ".flush_if_id"}, 32'(a.flush_if_id), 32'(e.flush_if_id));
      chk({tag, ".flush_id_ex"}, 32'(a.flush_id_ex), 32'(e.flush_id_ex));
      chk({tag, ".stall_cnt"},   ca,                 ce);
   endtask

   // Model state is advanced at the negedge; inputs stay stable until after the next posedge.
   initial begin : model0
      int          left = 0;
      int          left_n;
      logic [31:0] cnt  = 32'h0;
      outs_t       e, a;
      forever begin
         @(negedge clk);
         e = predict(rstn, bus0.ex_busy_i, bus0.jump_req_i, bus0.load_use_i, bus0.irq_req_i,
                     bus0.jump_addr_i, bus0.irq_vec_i, left, 1, left_n);
         a = {bus0.irq_ack_o, bus0.redirect_o, bus0.redirect_addr_o, bus0.stall_pc_o,
              bus0.stall_if_id_o, bus0.stall_id_ex_o, bus0.flush_if_id_o, bus0.flush_id_ex_o};
         check_inst("m0", e, a, cnt, bus0.stall_cnt_o);
         if (!rstn) cnt = 32'h0;
         else if (e.stall_pc) cnt = cnt + 32'd1;
         left = left_n;
      end
   end

   initial begin : model1
      int          left = 0;
      int          left_n;
      logic [31:0] cnt  = 32'hFFFF_FFFE;
      outs_t       e, a;
      forever begin
         @(negedge clk);
         e = predict(rstn, bus1.ex_busy_i, bus1.jump_req_i, bus1.load_use_i, bus1.irq_req_i,
                     bus1.jump_addr_i, bus1.irq_vec_i, left, 3, left_n);
         a = {bus1.irq_ack_o, bus1.redirect_o, bus1.redirect_addr_o, bus1.stall_pc_o,
              bus1.stall_if_id_o, bus1.stall_id_ex_o, bus1.flush_if_id_o, bus1.flush_id_ex_o};
         check_inst("m1", e, a, cnt, bus1.stall_cnt_o);
         if (!rstn) cnt = 32'hFFFF_FFFE;
         else if (e.stall_pc) cnt = cnt + 32'd1;
         left = left_n;
      end
   end

   // Applies one cycle of inputs, returns just after the model compare of that cycle.
   task automatic cyc(input logic r, b, j, input logic [31:0] ja, input logic l, i,
                      input logic [31:0] iv);
      @(posedge clk);
      #1;
      rstn             = r;
      bus0.ex_busy_i   = b;
      bus0.jump_req_i  = j;
      bus0.jump_addr_i = ja;
      bus0.load_use_i  = l;
      bus0.irq_req_i   = i;
      bus0.irq_vec_i   = iv;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rstn             = 1'b0;
      bus0.ex_busy_i   = 1'b0;
      bus0.jump_req_i  = 1'b0;
      bus0.jump_addr_i = 32'h0;
      bus0.load_use_i  = 1'b0;
      bus0.irq_req_i   = 1'b0;
      bus0.irq_vec_i   = 32'h0;

      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("rst_flush_if_id", 32'(bus0.flush_if_id_o), 32'd1);
      chk("rst_flush_id_ex", 32'(bus0.flush_id_ex_o), 32'd1);
      chk("rst_redirect",    32'(bus0.redirect_o),    32'd0);
      chk("rst_stall_pc",    32'(bus0.stall_pc_o),    32'd0);
      idle();
      chk("rst_cnt",         bus0.stall_cnt_o,        32'd0);
      chk("rst_flush_clear", 32'(bus0.flush_if_id_o), 32'd0);

      // Load-use for three cycles; dut1 counter starts two below the wrap point.
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("lu_stall_pc",    32'(bus0.stall_pc_o),    32'd1);
      chk("lu_flush_id_ex", 32'(bus0.flush_id_ex_o), 32'd1);
      chk("lu_stall_id_ex", 32'(bus0.stall_id_ex_o), 32'd0);
      chk("lu_cnt",         bus0.stall_cnt_o,        32'd2);
      chk("wrap_cnt",       bus1.stall_cnt_o,        32'd0);
      idle();
      chk("lu_cnt_after",   bus0.stall_cnt_o,        32'd3);
      chk("wrap_cnt_after", bus1.stall_cnt_o,        32'd1);

      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      idle();

      cyc(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      chk("jmp_redirect",    32'(bus0.redirect_o),    32'd1);
      chk("jmp_addr",        bus0.redirect_addr_o,    32'h100);
      chk("jmp_flush_id_ex", 32'(bus0.flush_id_ex_o), 32'd1);
      idle();
      chk("jmp1_flush_if_id", 32'(bus0.flush_if_id_o), 32'd1);
      chk("jmp1_flush_id_ex", 32'(bus0.flush_id_ex_o), 32'd0);
      chk("jmp1_redirect",    32'(bus0.redirect_o),    32'd0);
      idle();
      chk("jmp2_flush_if_id", 32'(bus0.flush_if_id_o), 32'd0);
      idle();

      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
         chk("busy_redirect",    32'(bus0.redirect_o),    32'd0);
         chk("busy_stall_id_ex", 32'(bus0.stall_id_ex_o), 32'd1);
      end
      cyc(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
      chk("busy_jmp_redirect", 32'(bus0.redirect_o), 32'd1);
      chk("busy_jmp_addr",     bus0.redirect_addr_o, 32'h200);
      chk("busy_cnt",          bus0.stall_cnt_o,     32'd4);
      idle();
      idle();

      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      idle();
      chk("lu1_cnt", bus0.stall_cnt_o, 32'd5);

      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
      chk("irq_ack",  32'(bus0.irq_ack_o), 32'd1);
      chk("irq_addr", bus0.redirect_addr_o, 32'h80);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
      chk("irq_wait_ack",   32'(bus0.irq_ack_o),     32'd0);
      chk("irq_wait_flush", 32'(bus0.flush_if_id_o), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
      chk("irq_late_ack", 32'(bus0.irq_ack_o), 32'd1);
      idle();
      idle();

      cyc(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 32'h340, 1'b0, 1'b0, 32'h0);
      chk("rejmp_redirect", 32'(bus0.redirect_o), 32'd1);
      chk("rejmp_addr",     bus0.redirect_addr_o, 32'h340);
      idle();
      chk("rejmp_flush1", 32'(bus0.flush_if_id_o), 32'd1);
      idle();
      chk("rejmp_flush2", 32'(bus0.flush_if_id_o), 32'd0);

      cyc(1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      idle();
      chk("rst_abort_flush", 32'(bus0.flush_if_id_o), 32'd0);
      chk("rst_abort_cnt",   bus0.stall_cnt_o,        32'd0);

      for (int k = 0; k < 3000; k++) begin
         cyc(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 4) == 0), 32'($urandom), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 3) == 0), 32'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
